// File: rtl/uart_rx.sv
// uart_rx: UART serial receiver with optional even parity.
//
// Recovers frames from the asynchronous TxD line and delivers each data word on RxData.
// The frame is a start bit (0), DATA_WIDTH data bits sent LSB first, an optional even-parity
// bit, and a stop bit (1). Each bit is sampled at the middle of its bit period.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-high reset
//   TxD        - serial line, asynchronous to clk, idles high
//   RxData     - last received word, held until the next completed frame
//   valid_rx   - one-cycle pulse for a frame with correct parity and stop bit
//   parity_err - one-cycle pulse when the received parity bit is wrong
//   frame_err  - one-cycle pulse when the stop bit is sampled low
//   busy       - high whenever the receiver is not idle
module uart_rx #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned PARITY_EN    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  TxD,
   output logic [DATA_WIDTH-1:0] RxData,
   output logic                  valid_rx,
   output logic                  parity_err,
   output logic                  frame_err,
   output logic                  busy
);

   localparam int unsigned H  = CLKS_PER_BIT / 2;
   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [CW-1:0] CntHalf = CW'(H - 1);
   localparam logic [CW-1:0] CntLast = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IdxLast = IW'(DATA_WIDTH - 1);
   localparam logic          ParEn   = (PARITY_EN != 0);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StBreak
   } state_t;

   logic                  r_sync1;
   logic                  r_sync2;
   logic [1:0]            r_fill;
   logic                  r_armed;
   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic [IW-1:0]         r_idx;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_perr;
   logic [DATA_WIDTH-1:0] r_rxdata;
   logic                  r_valid;
   logic                  r_perr_o;
   logic                  r_ferr;

   logic                  w_rxs;
   state_t                w_state_d;
   logic [CW-1:0]         w_cnt_d;
   logic [IW-1:0]         w_idx_d;
   logic [DATA_WIDTH-1:0] w_shift_d;
   logic                  w_perr_d;
   logic                  w_stop_smp;
   logic                  w_perr_flag;

   assign w_rxs       = r_sync2;
   assign w_perr_flag = r_perr & ParEn;

   always_comb begin
      w_state_d  = r_state;
      w_idx_d    = r_idx;
      w_shift_d  = r_shift;
      w_perr_d   = r_perr;
      w_stop_smp = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (r_armed && !w_rxs) begin
               w_state_d = StStart;
            end
         end
         StStart: begin
            w_idx_d = '0;
            if (r_cnt == CntHalf) begin
               w_state_d = w_rxs ? StIdle : StData;
            end
         end
         StData: begin
            if (r_cnt == CntLast) begin
               w_shift_d[r_idx] = w_rxs;
               if (r_idx == IdxLast) begin
                  w_state_d = ParEn ? StParity : StStop;
               end else begin
                  w_idx_d = r_idx + IW'(1);
               end
            end
         end
         StParity: begin
            if (r_cnt == CntLast) begin
               w_perr_d  = (^r_shift) ^ w_rxs;
               w_state_d = StStop;
            end
         end
         StStop: begin
            if (r_cnt == CntLast) begin
               w_stop_smp = 1'b1;
               w_state_d  = w_rxs ? StIdle : StBreak;
            end
         end
         StBreak: begin
            if (w_rxs) begin
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   // The counter restarts on every state change and at each bit boundary inside a state.
   assign w_cnt_d = ((w_state_d != r_state) || (r_cnt == CntLast)) ? '0 : r_cnt + CW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_fill   <= '0;
         r_armed  <= 1'b0;
         r_state  <= StIdle;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_shift  <= '0;
         r_perr   <= 1'b0;
         r_rxdata <= '0;
         r_valid  <= 1'b0;
         r_perr_o <= 1'b0;
         r_ferr   <= 1'b0;
      end else begin
         r_sync1  <= TxD;
         r_sync2  <= r_sync1;
         // r_fill marks when rxs reflects the real line rather than the synchronizer reset
         // value, so a release in mid-frame cannot arm the receiver on a fake idle level.
         r_fill   <= {r_fill[0], 1'b1};
         if (w_rxs && r_fill[1]) begin
            r_armed <= 1'b1;
         end
         r_state  <= w_state_d;
         r_cnt    <= w_cnt_d;
         r_idx    <= w_idx_d;
         r_shift  <= w_shift_d;
         r_perr   <= w_perr_d;
         r_valid  <= 1'b0;
         r_perr_o <= 1'b0;
         r_ferr   <= 1'b0;
         if (w_stop_smp) begin
            r_rxdata <= r_shift;
            r_ferr   <= ~w_rxs;
            r_perr_o <= w_perr_flag;
            r_valid  <= w_rxs & ~w_perr_flag;
         end
      end
   end

   assign RxData     = r_rxdata;
   assign valid_rx   = r_valid;
   assign parity_err = r_perr_o;
   assign frame_err  = r_ferr;
   assign busy       = (r_state != StIdle);

endmodule
